regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard and optional write-to-read bypass. It replaces the single-write, two-read register file in the core. It serves a dual-issue or multi-writeback pipeline: decode reads operands and allocates destinations, and writeback ports retire results and clear the busy bits.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREG), register address width (derived, not overridable)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see registered state only
ZERO_REG, 1, 1 = register 0 hard-wired to zero and never busy

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NRD*XLEN  read data, combinational from raddr
rbusy  out  NRD  1 = operand at raddr[i] still pending (consumer must stall)
wen  in  NWR  write enable per port
waddr  in  NWR*AW  write addresses
wdata  in  NWR*XLEN  write data
alloc_en  in  1  request to mark alloc_addr busy (destination allocation)
alloc_addr  in  AW  register to allocate
alloc_ok  out  1  combinational; 1 = allocation accepted this cycle
flush  in  1  synchronous clear of all busy bits (pipeline flush)

Behaviour:
- Reset: the asynchronous assert of rstn clears all registers to 0 and all busy bits to 0. While in reset, rdata = 0, rbusy = 0, and alloc_ok = 1 if alloc_en is asserted.
- Write: a write port with wen[j] = 1 updates reg[waddr[j]] at the next rising edge. If several ports target the same address in one cycle, the highest port index wins.
- ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 with rbusy = 0.
  - alloc on address 0 returns alloc_ok = 1 and sets no state.
- Read, BYPASS = 1: if any wen[j] matches raddr[i] this cycle, rdata[i] = the winning wdata (same highest-index rule). Otherwise rdata[i] = the stored register.
- Read, BYPASS = 0: rdata[i] is the stored register only. Latency is one cycle after the write edge.
- rbusy[i] = busy[raddr[i]]. When BYPASS = 1, rbusy[i] is additionally masked to 0 if a write to that address occurs this cycle.
- Scoreboard allocation: alloc_ok = alloc_en & ~busy[alloc_addr], with the same-cycle write-clear visible when BYPASS = 1.
  - An accepted alloc sets busy[alloc_addr] at the next edge.
  - A rejected alloc (target busy) changes no state; the requester holds alloc_en and alloc_addr until accepted.
- Busy clear: any wen[j] clears busy[waddr[j]] at the next edge.
- Same-cycle alloc and write to the same address: the write updates the data, and busy ends at 1 because the new producer wins. With BYPASS = 0 the alloc is rejected if busy was already set.
- flush: all busy bits go to 0 at the next edge. Register data is untouched, and writes in the same cycle still commit. flush has priority over alloc, so an alloc in a flush cycle is dropped even if alloc_ok = 1. The requester must ignore alloc_ok while flush = 1.
- Reset during operation: all pending busy bits are lost, and in-flight writes in that cycle do not commit.

Decomposition:
- The shared defines file gains the default values for XLEN, NREG, NRD and NWR, plus the enable/disable and zero-word constants already used core-wide. This block defines no new global macros.
- Sub-module rf_wr_select: for one target address, a combinational priority resolver over NWR ports, producing a hit flag and the winning data. It is instantiated once per register (write path) and once per read port (bypass path).
- Storage per register uses the team's enable-gated reset DFF cell with a zero reset value. The busy vector is a single NREG-bit register inside the top module.

Test Plan:
- Reset, then read addresses 1 and 31 on both ports -> rdata = 0x00000000, rbusy = 0; alloc_en with addr 5 -> alloc_ok = 1.
- Write port 0 with addr 3, data 0xDEADBEEF, while reading addr 3 in the same cycle -> BYPASS = 1: rdata = 0xDEADBEEF that cycle; BYPASS = 0: old value, then 0xDEADBEEF on the next cycle.
- Both write ports target addr 7 (port 0 data 0x11, port 1 data 0x22) -> stored value and bypassed value = 0x22.
- Alloc addr 9 accepted, then a second alloc addr 9 -> alloc_ok = 0 and rbusy = 1 on reads of 9. Then write port 1 with addr 9, data 0x55 -> busy cleared, rdata = 0x55, and a re-alloc of 9 is accepted.
- Alloc addr 4 and write addr 4 in the same cycle with busy[4] = 0 -> data committed, busy[4] = 1 afterwards.
- Alloc addresses 2, 6 and 10, then pulse flush together with alloc addr 12 -> all rbusy = 0 after the edge, busy[12] = 0. Write addr 0 with data 0xFFFFFFFF -> read of 0 returns 0.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file.
// Holds the core-wide default sizes and the on/off encoding used by the
// BYPASS and ZERO_REG build options. No ports.
package regfile_mp_sb_pkg;

    localparam int RF_XLEN_DEF = 32;
    localparam int RF_NREG_DEF = 32;
    localparam int RF_NRD_DEF  = 2;
    localparam int RF_NWR_DEF  = 2;

    localparam int RF_OFF = 0;
    localparam int RF_ON  = 1;

endpackage : regfile_mp_sb_pkg

// File: rtl/regfile_mp_sb_wr_select.sv
// Priority resolver over all write ports for a single target address.
// Ports:
//   tgt_addr - register address being resolved
//   wen      - write enable per port
//   waddr    - packed write addresses, port j at [j*AW +: AW]
//   wdata    - packed write data, port j at [j*XLEN +: XLEN]
//   hit      - 1 when any enabled port targets tgt_addr
//   data     - data of the highest-index matching port ('0 when no hit)
module rf_wr_select #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]       tgt_addr,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (waddr[j*AW +: AW] == tgt_addr)) begin
                hit  = 1'b1;
                data = wdata[j*XLEN +: XLEN];
            end
        end
    end

endmodule : rf_wr_select

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard and
// optional same-cycle write-to-read bypass.
// Ports:
//   clk, rstn            - clock (rising edge), asynchronous active-low reset
//   raddr/rdata/rbusy    - NRD combinational read ports with pending flag
//   wen/waddr/wdata      - NWR write ports; a write also clears busy
//   alloc_en/alloc_addr  - destination allocation request
//   alloc_ok             - combinational acceptance of the allocation
//   flush                - clears every busy bit at the next edge
import regfile_mp_sb_pkg::*;

module regfile_mp_sb #(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREG     = RF_NREG_DEF,
    parameter int NRD      = RF_NRD_DEF,
    parameter int NWR      = RF_NWR_DEF,
    parameter int BYPASS   = RF_ON,
    parameter int ZERO_REG = RF_ON,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                alloc_ok,
    input  logic                flush
);

    logic [XLEN-1:0] regs    [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            alloc_zero;
    logic            alloc_busy;

    // Write path: one resolver and one enable-gated flop per register.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam logic [AW-1:0] RIDX = AW'(r);
        // Register 0 never loads when hard-wired, so it holds its reset zero.
        localparam bit WRITABLE = !((ZERO_REG != RF_OFF) && (r == 0));
        logic [XLEN-1:0] q;

        rf_wr_select #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
            .tgt_addr (RIDX),
            .wen      (wen),
            .waddr    (waddr),
            .wdata    (wdata),
            .hit      (wr_hit[r]),
            .data     (wr_data[r])
        );

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                q <= '0;
            end else if (wr_hit[r] && WRITABLE) begin
                q <= wr_data[r];
            end
        end

        assign regs[r] = q;
    end

    // Read path: optional bypass resolver per port; all outputs forced quiet
    // while reset is held so in-flight write data is not forwarded.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            is_zero;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;

        assign ra      = raddr[i*AW +: AW];
        assign is_zero = (ZERO_REG != RF_OFF) && (ra == '0);

        if (BYPASS == RF_ON) begin : g_byp
            rf_wr_select #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_rsel (
                .tgt_addr (ra),
                .wen      (wen),
                .waddr    (waddr),
                .wdata    (wdata),
                .hit      (byp_hit),
                .data     (byp_data)
            );
        end else begin : g_nobyp
            assign byp_hit  = 1'b0;
            assign byp_data = '0;
        end

        assign rdata[i*XLEN +: XLEN] = (!rstn || is_zero) ? '0 :
                                       byp_hit            ? byp_data :
                                                            regs[ra];
        assign rbusy[i] = rstn && !is_zero && busy[ra] && !byp_hit;
    end

    // Allocation: busy is already zero during reset, so no reset term is needed.
    // With bypass, a write landing this cycle frees the target immediately.
    assign alloc_zero = (ZERO_REG != RF_OFF) && (alloc_addr == '0);
    assign alloc_busy = busy[alloc_addr] &&
                        !((BYPASS == RF_ON) && wr_hit[alloc_addr]);
    assign alloc_ok   = alloc_en && (alloc_zero || !alloc_busy);

    // Writes clear, an accepted alloc sets afterwards (new producer wins),
    // and flush overrides both.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (alloc_ok && !alloc_zero) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb. Two instances share stimulus: u_dut with
// bypass enabled and u_nb with bypass disabled (both with register 0 zeroed).
module tb_regfile_mp_sb;

    logic        clk;
    logic        rstn;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        alloc_ok, alloc_ok_nb;
    logic        flush;

    int vec_cnt = 0;
    int err_cnt = 0;

    regfile_mp_sb #(.BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .alloc_ok(alloc_ok), .flush(flush)
    );

    regfile_mp_sb #(.BYPASS(0), .ZERO_REG(1)) u_nb (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_nb), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking inside).
    task automatic idle();
        wen = '0; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        raddr[p*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1;
        waddr[p*5 +: 5] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd(0, 5'd1); rd(1, 5'd31);
        alloc_en = 1'b1; alloc_addr = 5'd5;
        #2;
        vec_cnt++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_rd: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        vec_cnt++;
        if (alloc_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_alloc: alloc_ok=%b want 1", alloc_ok);
        end
        alloc_en = 1'b0;
        rstn = 1'b1;
        #1;
        vec_cnt++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL post_reset_rd: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        wr(0, 5'd3, 32'hDEADBEEF);
        rd(0, 5'd3); rd(1, 5'd1);
        #1;
        vec_cnt++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL bypass_same_cycle: got %h want DEADBEEF", rdata[31:0]);
        end
        vec_cnt++;
        if (rdata_nb[31:0] !== 32'h0) begin
            err_cnt++;
            $display("FAIL nobypass_same_cycle: got %h want 00000000", rdata_nb[31:0]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rdata[31:0] !== 32'hDEADBEEF || rdata_nb[31:0] !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL write_commit: byp=%h nb=%h want DEADBEEF", rdata[31:0], rdata_nb[31:0]);
        end
    endtask

    task automatic test_same_addr();
        idle();
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
        rd(1, 5'd7);
        #1;
        vec_cnt++;
        if (rdata[63:32] !== 32'h22) begin
            err_cnt++;
            $display("FAIL prio_bypass: got %h want 00000022", rdata[63:32]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rdata[63:32] !== 32'h22 || rdata_nb[63:32] !== 32'h22) begin
            err_cnt++;
            $display("FAIL prio_store: byp=%h nb=%h want 00000022", rdata[63:32], rdata_nb[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd(0, 5'd9); rd(1, 5'd9);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        vec_cnt++;
        if (alloc_ok !== 1'b1 || alloc_ok_nb !== 1'b1) begin
            err_cnt++;
            $display("FAIL alloc9_first: byp=%b nb=%b want 1", alloc_ok, alloc_ok_nb);
        end
        tick();
        #1;
        vec_cnt++;
        if (alloc_ok !== 1'b0 || alloc_ok_nb !== 1'b0) begin
            err_cnt++;
            $display("FAIL alloc9_reject: byp=%b nb=%b want 0", alloc_ok, alloc_ok_nb);
        end
        vec_cnt++;
        if (rbusy !== 2'b11 || rbusy_nb !== 2'b11) begin
            err_cnt++;
            $display("FAIL busy9: byp=%b nb=%b want 11", rbusy, rbusy_nb);
        end
        alloc_en = 1'b0;
        wr(1, 5'd9, 32'h55);
        #1;
        vec_cnt++;
        if (rbusy !== 2'b00 || rdata[31:0] !== 32'h55) begin
            err_cnt++;
            $display("FAIL wb9_bypass: rbusy=%b rdata=%h want 00/00000055", rbusy, rdata[31:0]);
        end
        vec_cnt++;
        if (rbusy_nb !== 2'b11) begin
            err_cnt++;
            $display("FAIL wb9_nobypass_busy: rbusy=%b want 11", rbusy_nb);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rbusy_nb !== 2'b00 || rdata_nb[31:0] !== 32'h55 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL wb9_commit: nb rbusy=%b rdata=%h byp rbusy=%b want 00/55/00",
                     rbusy_nb, rdata_nb[31:0], rbusy);
        end
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        vec_cnt++;
        if (alloc_ok !== 1'b1 || alloc_ok_nb !== 1'b1) begin
            err_cnt++;
            $display("FAIL realloc9: byp=%b nb=%b want 1", alloc_ok, alloc_ok_nb);
        end
        tick();
        idle();
    endtask

    task automatic test_alloc_write_same();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd4;
        wr(0, 5'd4, 32'h44);
        rd(0, 5'd4); rd(1, 5'd4);
        #1;
        vec_cnt++;
        if (alloc_ok !== 1'b1 || alloc_ok_nb !== 1'b1) begin
            err_cnt++;
            $display("FAIL alloc_wr4_ok: byp=%b nb=%b want 1", alloc_ok, alloc_ok_nb);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rdata[31:0] !== 32'h44 || rbusy !== 2'b11 || rbusy_nb !== 2'b11) begin
            err_cnt++;
            $display("FAIL alloc_wr4_state: rdata=%h rbusy=%b nb=%b want 44/11/11",
                     rdata[31:0], rbusy, rbusy_nb);
        end
    endtask

    task automatic test_flush();
        logic [4:0] al [3];
        al[0] = 5'd2; al[1] = 5'd6; al[2] = 5'd10;
        for (int k = 0; k < 3; k++) begin
            idle();
            alloc_en = 1'b1; alloc_addr = al[k];
            #1;
            vec_cnt++;
            if (alloc_ok !== 1'b1) begin
                err_cnt++;
                $display("FAIL alloc_pre_flush[%0d]: got %b want 1", al[k], alloc_ok);
            end
            tick();
        end
        idle();
        rd(0, 5'd2); rd(1, 5'd10);
        #1;
        vec_cnt++;
        if (rbusy !== 2'b11) begin
            err_cnt++;
            $display("FAIL busy_pre_flush: got %b want 11", rbusy);
        end
        flush = 1'b1;
        alloc_en = 1'b1; alloc_addr = 5'd12;
        wr(0, 5'd13, 32'h1313);
        tick();
        idle();
        rd(0, 5'd2); rd(1, 5'd6);
        #1;
        vec_cnt++;
        if (rbusy !== 2'b00 || rbusy_nb !== 2'b00) begin
            err_cnt++;
            $display("FAIL flush_2_6: byp=%b nb=%b want 00", rbusy, rbusy_nb);
        end
        rd(0, 5'd10); rd(1, 5'd12);
        #1;
        vec_cnt++;
        if (rbusy !== 2'b00 || rbusy_nb !== 2'b00) begin
            err_cnt++;
            $display("FAIL flush_10_12: byp=%b nb=%b want 00", rbusy, rbusy_nb);
        end
        rd(0, 5'd9); rd(1, 5'd4);
        #1;
        vec_cnt++;
        if (rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL flush_9_4: got %b want 00", rbusy);
        end
        rd(0, 5'd13);
        #1;
        vec_cnt++;
        if (rdata[31:0] !== 32'h1313 || rbusy[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_write_commit: rdata=%h rbusy=%b want 00001313/0", rdata[31:0], rbusy[0]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr(0, 5'd0, 32'hFFFFFFFF);
        rd(0, 5'd0); rd(1, 5'd0);
        alloc_en = 1'b1; alloc_addr = 5'd0;
        #1;
        vec_cnt++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL zero_bypass: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        vec_cnt++;
        if (alloc_ok !== 1'b1 || alloc_ok_nb !== 1'b1) begin
            err_cnt++;
            $display("FAIL zero_alloc: byp=%b nb=%b want 1", alloc_ok, alloc_ok_nb);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rdata !== 64'h0 || rdata_nb !== 64'h0 || rbusy !== 2'b00 || rbusy_nb !== 2'b00) begin
            err_cnt++;
            $display("FAIL zero_store: rdata=%h nb=%h rbusy=%b/%b want 0", rdata, rdata_nb, rbusy, rbusy_nb);
        end
    endtask

    task automatic test_reset_midop();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd14;
        tick();
        idle();
        wr(0, 5'd15, 32'hABCD);
        rd(0, 5'd15); rd(1, 5'd14);
        rstn = 1'b0;
        #1;
        vec_cnt++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL in_reset_quiet: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        tick();
        idle();
        rstn = 1'b1;
        #1;
        vec_cnt++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_drop: rdata=%h rbusy=%b want 0/00", rdata, rbusy);
        end
        rd(0, 5'd3); rd(1, 5'd7);
        #1;
        vec_cnt++;
        if (rdata !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_clears_data: rdata=%h want 0", rdata);
        end
    endtask

    initial begin
        rstn = 1'b0;
        raddr = '0;
        idle();
        test_reset();
        test_bypass();
        test_same_addr();
        test_scoreboard();
        test_alloc_write_same();
        test_flush();
        test_zero_reg();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_regfile_mp_sb
